// File: rtl/cargador_memoria_programa_pkg.sv
// Shared definitions for the program-memory loader: FSM encoding, default halt word
// and the address-width helper also used by memoria_programa.
package cargador_memoria_programa_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_WRITE = 3'd2,
    ST_DONE  = 3'd3,
    ST_ERROR = 3'd4
  } state_t;

  localparam logic [31:0] HALT_WORD_DEFAULT = 32'hFFFF_FFFF;

  // Bits needed to count up to depth inclusive; address width is this minus one.
  function automatic int clogb2(input int depth);
    int d;
    int r;
    d = depth;
    for (r = 0; d > 0; r++) begin
      d = d >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/cargador_memoria_programa_if.sv
// Byte-stream input and program-memory write port of the loader, plus FSM debug state.
interface cargador_memoria_programa_if #(
  parameter int RAM_WIDTH = 32,
  parameter int NB_COL    = 4,
  parameter int COL_WIDTH = 8,
  parameter int NB_ADDR   = 11
);
  import cargador_memoria_programa_pkg::*;

  // Handshake: i_byte_valid is a one-cycle strobe qualifying i_byte, with no ready
  // (the loader always accepts); o_ena/o_wea form a one-cycle write strobe that
  // qualifies o_addr/o_data, with no backpressure from the memory.
  logic                 i_start;
  logic [COL_WIDTH-1:0] i_byte;
  logic                 i_byte_valid;
  logic [NB_ADDR-1:0]   o_addr;
  logic [RAM_WIDTH-1:0] o_data;
  logic [NB_COL-1:0]    o_wea;
  logic                 o_ena;
  logic                 o_busy;
  logic                 o_done;
  logic                 o_error;
  logic [NB_ADDR:0]     o_word_count;
  state_t               state;

  modport slave (
    input  i_start, i_byte, i_byte_valid,
    output o_addr, o_data, o_wea, o_ena, o_busy, o_done, o_error, o_word_count, state
  );

  modport master (
    output i_start, i_byte, i_byte_valid,
    input  o_addr, o_data, o_wea, o_ena, o_busy, o_done, o_error, o_word_count, state
  );

endinterface

// File: rtl/cargador_memoria_programa.sv
// Assembles received bytes big-endian into words and writes them to sequential
// program-memory addresses until the halt word is written or memory is full.
module cargador_memoria_programa
  import cargador_memoria_programa_pkg::*;
#(
  parameter int RAM_WIDTH = 32,
  parameter int NB_COL    = 4,
  parameter int COL_WIDTH = 8,
  parameter int RAM_DEPTH = 2048,
  parameter logic [RAM_WIDTH-1:0] HALT_WORD = HALT_WORD_DEFAULT
) (
  input  logic i_clk,
  input  logic i_soft_reset,
  cargador_memoria_programa_if.slave bus
);

  localparam int NB_ADDR = clogb2(RAM_DEPTH) - 1;
  localparam int NB_IDX  = (NB_COL > 1) ? $clog2(NB_COL) : 1;
  localparam int SH_W    = RAM_WIDTH - COL_WIDTH;
  localparam logic [NB_ADDR-1:0] LAST_ADDR = NB_ADDR'(RAM_DEPTH - 1);
  localparam logic [NB_IDX-1:0]  LAST_IDX  = NB_IDX'(NB_COL - 1);

  state_t               state_q, state_d;
  logic [SH_W-1:0]      shift_q;
  logic [NB_IDX-1:0]    idx_q;
  logic [NB_ADDR-1:0]   addr_q;
  logic [RAM_WIDTH-1:0] data_q;
  logic [NB_ADDR:0]     count_q;

  logic clear_load;
  logic take_byte;
  logic word_latch;
  logic addr_inc;
  logic count_inc;

  always_ff @(posedge i_clk or negedge i_soft_reset) begin
    if (!i_soft_reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    clear_load = 1'b0;
    take_byte  = 1'b0;
    word_latch = 1'b0;
    addr_inc   = 1'b0;
    count_inc  = 1'b0;
    unique case (state_q)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        // A start wins over a byte arriving in the same cycle.
        if (bus.i_start) begin
          clear_load = 1'b1;
          state_d    = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (bus.i_byte_valid) begin
          take_byte = 1'b1;
          if (idx_q == LAST_IDX) begin
            word_latch = 1'b1;
            state_d    = ST_WRITE;
          end
        end
      end
      ST_WRITE: begin
        count_inc = 1'b1;
        if (data_q == HALT_WORD) begin
          state_d = ST_DONE;
        end else if (addr_q == LAST_ADDR) begin
          state_d = ST_ERROR;
        end else begin
          addr_inc = 1'b1;
          state_d  = ST_LOAD;
          // A byte landing on the write cycle starts the next word.
          take_byte = bus.i_byte_valid;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_soft_reset) begin
    if (!i_soft_reset) begin
      shift_q <= '0;
      idx_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      count_q <= '0;
    end else begin
      if (clear_load) begin
        shift_q <= '0;
        idx_q   <= '0;
        addr_q  <= '0;
        count_q <= '0;
      end
      if (take_byte) begin
        shift_q <= {shift_q[SH_W-COL_WIDTH-1:0], bus.i_byte};
        if (word_latch) begin
          data_q <= {shift_q, bus.i_byte};
          idx_q  <= '0;
        end else begin
          idx_q <= idx_q + NB_IDX'(1);
        end
      end
      if (addr_inc) begin
        addr_q <= addr_q + NB_ADDR'(1);
      end
      if (count_inc) begin
        count_q <= count_q + (NB_ADDR + 1)'(1);
      end
    end
  end

  assign bus.o_addr       = addr_q;
  assign bus.o_data       = data_q;
  assign bus.o_wea        = {NB_COL{state_q == ST_WRITE}};
  assign bus.o_ena        = (state_q == ST_WRITE);
  assign bus.o_busy       = (state_q == ST_LOAD) || (state_q == ST_WRITE);
  assign bus.o_done       = (state_q == ST_DONE);
  assign bus.o_error      = (state_q == ST_ERROR);
  assign bus.o_word_count = count_q;
  assign bus.state        = state_q;

endmodule

// File: tb/tb_cargador_memoria_programa.sv
// Bench for the program loader: two instances (full depth and depth 4) share one
// byte stream and are checked each cycle against a word-level loader model.
module tb_cargador_memoria_programa;
  import cargador_memoria_programa_pkg::*;

  localparam int DEPTH0 = 2048;
  localparam int DEPTH1 = 4;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       start = 1'b0;
  logic       bv    = 1'b0;
  logic [7:0] byt   = 8'h00;

  cargador_memoria_programa_if #(.RAM_WIDTH(32), .NB_COL(4), .COL_WIDTH(8), .NB_ADDR(11)) bus0 ();
  cargador_memoria_programa_if #(.RAM_WIDTH(32), .NB_COL(4), .COL_WIDTH(8), .NB_ADDR(2))  bus1 ();

  assign bus0.i_start = start;
  assign bus0.i_byte_valid = bv;
  assign bus0.i_byte = byt;
  assign bus1.i_start = start;
  assign bus1.i_byte_valid = bv;
  assign bus1.i_byte = byt;

  cargador_memoria_programa #(.RAM_DEPTH(DEPTH0)) dut0 (
    .i_clk(clk), .i_soft_reset(rst_n), .bus(bus0.slave)
  );
  cargador_memoria_programa #(.RAM_DEPTH(DEPTH1)) dut1 (
    .i_clk(clk), .i_soft_reset(rst_n), .bus(bus1.slave)
  );

  // Both instances' outputs widened into common arrays.
  logic [10:0] o_addr [2];
  logic [31:0] o_data [2];
  logic [3:0]  o_wea  [2];
  logic        o_ena  [2];
  logic        o_busy [2];
  logic        o_done [2];
  logic        o_err  [2];
  logic [11:0] o_cnt  [2];

  always_comb begin
    o_addr[0] = bus0.o_addr;          o_addr[1] = 11'(bus1.o_addr);
    o_data[0] = bus0.o_data;          o_data[1] = bus1.o_data;
    o_wea[0]  = bus0.o_wea;           o_wea[1]  = bus1.o_wea;
    o_ena[0]  = bus0.o_ena;           o_ena[1]  = bus1.o_ena;
    o_busy[0] = bus0.o_busy;          o_busy[1] = bus1.o_busy;
    o_done[0] = bus0.o_done;          o_done[1] = bus1.o_done;
    o_err[0]  = bus0.o_error;         o_err[1]  = bus1.o_error;
    o_cnt[0]  = bus0.o_word_count;    o_cnt[1]  = 12'(bus1.o_word_count);
  end

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  int        depth [2] = '{DEPTH0, DEPTH1};
  bit        m_act  [2];
  bit        m_wr   [2];
  bit        m_done [2];
  bit        m_err  [2];
  int        m_addr [2];
  int        m_cnt  [2];
  bit [31:0] m_data [2];
  bit [7:0]  m_q    [2][$];
  bit [42:0] exp_q  [2][$];

  task automatic model_clear();
    for (int d = 0; d < 2; d++) begin
      m_act[d] = 0; m_wr[d] = 0; m_done[d] = 0; m_err[d] = 0;
      m_addr[d] = 0; m_cnt[d] = 0; m_data[d] = '0;
      m_q[d].delete();
      exp_q[d].delete();
    end
  endtask

  task automatic model_step(input int d);
    if (m_wr[d]) begin
      m_wr[d] = 0;
      m_cnt[d]++;
      if (m_data[d] == 32'hFFFF_FFFF) begin
        m_act[d] = 0; m_done[d] = 1;
      end else if (m_addr[d] == depth[d] - 1) begin
        m_act[d] = 0; m_err[d] = 1;
      end else begin
        m_addr[d]++;
        if (bv) m_q[d].push_back(byt);
      end
    end else if (m_act[d]) begin
      if (bv) begin
        m_q[d].push_back(byt);
        if (m_q[d].size() == 4) begin
          m_data[d] = {m_q[d][0], m_q[d][1], m_q[d][2], m_q[d][3]};
          m_q[d].delete();
          m_wr[d] = 1;
          exp_q[d].push_back({11'(m_addr[d]), m_data[d]});
        end
      end
    end else if (start) begin
      m_act[d] = 1; m_done[d] = 0; m_err[d] = 0;
      m_addr[d] = 0; m_cnt[d] = 0;
      m_q[d].delete();
    end
  endtask

  always @(negedge rst_n) model_clear();

  always @(posedge clk) begin
    if (!rst_n) model_clear();
    else for (int d = 0; d < 2; d++) model_step(d);
  end

  // ---------------- compare + scoreboard ----------------
  int        wr_cnt   [2];
  bit [31:0] last_wr  [2];
  bit [10:0] last_adr [2];
  logic [31:0] mem0 [DEPTH0];

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("busy[%0d]", d),  64'(o_busy[d]), 64'(m_act[d]));
      chk($sformatf("done[%0d]", d),  64'(o_done[d]), 64'(m_done[d]));
      chk($sformatf("error[%0d]", d), 64'(o_err[d]),  64'(m_err[d]));
      chk($sformatf("ena[%0d]", d),   64'(o_ena[d]),  64'(m_wr[d]));
      chk($sformatf("wea[%0d]", d),   64'(o_wea[d]),  m_wr[d] ? 64'hF : 64'h0);
      chk($sformatf("addr[%0d]", d),  64'(o_addr[d]), 64'(m_addr[d]));
      chk($sformatf("count[%0d]", d), 64'(o_cnt[d]),  64'(m_cnt[d]));
      chk($sformatf("data[%0d]", d),  64'(o_data[d]), 64'(m_data[d]));
      if (o_ena[d] === 1'b1) begin
        wr_cnt[d]++;
        last_wr[d]  = o_data[d];
        last_adr[d] = o_addr[d];
        if (d == 0) mem0[o_addr[0]] = o_data[0];
        if (exp_q[d].size() == 0) begin
          chk($sformatf("unexpected_write[%0d]", d), {21'd0, o_addr[d], o_data[d]}, 64'h0);
        end else begin
          chk($sformatf("write[%0d]", d), {21'd0, o_addr[d], o_data[d]}, 64'(exp_q[d].pop_front()));
        end
      end
    end
  end

  // ---------------- driver tasks (called at a falling edge) ----------------
  task automatic drive(input bit s, input bit v, input logic [7:0] b);
    start = s; bv = v; byt = b;
    @(negedge clk);
    start = 0; bv = 0; byt = 8'h00;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) drive(0, 1, w[31-8*i -: 8]);
  endtask

  task automatic do_reset();
    #2 rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic chk_zero(input int d, input string tag);
    chk({tag, "_addr"}, 64'(o_addr[d]), 64'h0);
    chk({tag, "_data"}, 64'(o_data[d]), 64'h0);
    chk({tag, "_busy"}, 64'(o_busy[d]), 64'h0);
    chk({tag, "_done"}, 64'(o_done[d]), 64'h0);
    chk({tag, "_cnt"},  64'(o_cnt[d]),  64'h0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    repeat (3) @(negedge clk);
    chk_zero(0, "rst0");
    chk_zero(1, "rst1");
    rst_n = 1'b1;
    @(negedge clk);

    // Bytes while idle are ignored.
    send_word(32'h0102_0304);
    idle(2);
    chk("idle_bytes_writes", 64'(wr_cnt[0]), 64'd0);
    chk("idle_bytes_busy", 64'(o_busy[0]), 64'd0);

    // Single word.
    drive(1, 0, 8'h00);
    send_word(32'h1234_5678);
    idle(2);
    chk("w1_data", 64'(last_wr[0]), 64'h1234_5678);
    chk("w1_addr_after", 64'(o_addr[0]), 64'd1);
    chk("w1_count", 64'(o_cnt[0]), 64'd1);

    // Start during LOAD ignored; a byte in the same cycle is still taken.
    drive(1, 0, 8'h00);
    drive(1, 1, 8'h9A);
    drive(0, 1, 8'hBC);
    drive(0, 1, 8'hDE);
    drive(0, 1, 8'hF0);
    idle(2);
    chk("ld_start_data", 64'(last_wr[0]), 64'h9ABC_DEF0);
    chk("ld_start_addr", 64'(last_adr[0]), 64'd1);
    send_word(32'hFFFF_FFFF);
    idle(2);
    chk("halt_done", 64'(o_done[0]), 64'd1);
    chk("halt_count", 64'(o_cnt[0]), 64'd3);

    // Restart from DONE; the byte sharing the start cycle is dropped.
    drive(1, 1, 8'h77);
    send_word(32'h0000_0005);
    idle(1);
    send_word(32'h0000_000A);
    idle(1);
    send_word(32'hFFFF_FFFF);
    idle(2);
    chk("s2_done", 64'(o_done[0]), 64'd1);
    chk("s2_count", 64'(o_cnt[0]), 64'd3);
    chk("s2_addr", 64'(o_addr[0]), 64'd2);
    chk("s2_mem0", 64'(mem0[0]), 64'h5);
    chk("s2_mem1", 64'(mem0[1]), 64'hA);

    // Byte landing on the write cycle becomes the next word's MSB.
    drive(1, 0, 8'h00);
    send_word(32'h1122_3344);
    send_word(32'hAABB_CCDD);
    idle(2);
    chk("wrcycle_data", 64'(last_wr[0]), 64'hAABB_CCDD);
    chk("wrcycle_addr", 64'(last_adr[0]), 64'd1);
    send_word(32'hFFFF_FFFF);
    idle(2);

    // Overflow on the depth-4 instance.
    drive(1, 0, 8'h00);
    for (int i = 0; i < 4; i++) begin
      send_word(32'h0101_0101 * (i + 1));
      idle(1);
    end
    idle(1);
    chk("ovf_error", 64'(o_err[1]), 64'd1);
    chk("ovf_done", 64'(o_done[1]), 64'd0);
    chk("ovf_count", 64'(o_cnt[1]), 64'd4);
    chk("ovf_last_addr", 64'(last_adr[1]), 64'd3);
    chk("ovf_big_busy", 64'(o_busy[0]), 64'd1);

    // Halt at the last address ends in DONE.
    drive(1, 0, 8'h00);
    for (int i = 0; i < 3; i++) begin
      send_word(32'h0000_0010 + i);
      idle(1);
    end
    send_word(32'hFFFF_FFFF);
    idle(2);
    chk("lasthalt_done", 64'(o_done[1]), 64'd1);
    chk("lasthalt_error", 64'(o_err[1]), 64'd0);
    chk("lasthalt_count", 64'(o_cnt[1]), 64'd4);
    chk("lasthalt_addr", 64'(last_adr[1]), 64'd3);

    // Reset in the middle of a word.
    drive(1, 0, 8'h00);
    drive(0, 1, 8'h12);
    drive(0, 1, 8'h34);
    begin
      int wr_before;
      wr_before = wr_cnt[0];
      do_reset();
      chk_zero(0, "midrst0");
      chk_zero(1, "midrst1");
      chk("midrst_no_write", 64'(wr_cnt[0]), 64'(wr_before));
    end
    drive(1, 0, 8'h00);
    send_word(32'hDEAD_BEEF);
    idle(2);
    chk("postrst_data", 64'(last_wr[0]), 64'hDEAD_BEEF);
    chk("postrst_addr", 64'(last_adr[0]), 64'd0);
    chk("postrst_count", 64'(o_cnt[0]), 64'd1);

    chk("exp_q0_empty", 64'(exp_q[0].size()), 64'd0);
    chk("exp_q1_empty", 64'(exp_q[1].size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
